// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush scheduler for the 5-stage pipeline.
// Inputs: Clk, Reset (sync, active-high), IF/ID register fields, ID/EX load
//   info, EX/MEM mem-op/branch info, mem_ack from data memory.
// Outputs: PCWrite/PCSrc, per-stage Write/Flush/Bubble, mem_req,
//   sticky mem_err, stall_cnt/flush_cnt statistics.
// Statistics counters are built only with `define PIPE_HAZARD_STATS_EN.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_uses_rt,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rt,
    input  logic             EXMEM_MemRead,
    input  logic             EXMEM_MemWrite,
    input  logic             EXMEM_Branch,
    input  logic             EXMEM_Zero,
    input  logic             mem_ack,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Write,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Write,
    output logic             EXMEM_Bubble,
    output logic             MEMWB_Bubble,
    output logic             mem_req,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam logic [7:0] TLAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic       err_q, err_d;

    logic taken;
    logic load_use;

    assign taken = EXMEM_Branch & EXMEM_Zero;

    assign load_use = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                      ((IDEX_rt == IFID_rs) ||
                       (IFID_uses_rt && (IDEX_rt == IFID_rt)));

    assign mem_err = err_q;

    always_comb begin
        PCWrite      = 1'b1;
        PCSrc        = 1'b0;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        EXMEM_Write  = 1'b1;
        EXMEM_Bubble = 1'b0;
        MEMWB_Bubble = 1'b0;
        mem_req      = 1'b0;
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        err_d        = err_q;

        if (Reset) begin
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            IFID_Flush   = 1'b1;
            IDEX_Bubble  = 1'b1;
            EXMEM_Bubble = 1'b1;
            MEMWB_Bubble = 1'b1;
            state_d      = RUN;
            tcnt_d       = 8'd0;
            err_d        = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    mem_req = EXMEM_MemRead | EXMEM_MemWrite;
                    if (mem_req && !mem_ack) begin
                        // Memory not ready: hold every stage, drain MEM/WB.
                        PCWrite      = 1'b0;
                        IFID_Write   = 1'b0;
                        IDEX_Write   = 1'b0;
                        EXMEM_Write  = 1'b0;
                        MEMWB_Bubble = 1'b1;
                        state_d      = MEM_WAIT;
                        tcnt_d       = 8'd0;
                    end else if (taken) begin
                        // Taken branch wins over a coincident load-use stall.
                        PCSrc        = 1'b1;
                        IFID_Flush   = 1'b1;
                        IDEX_Bubble  = 1'b1;
                        EXMEM_Bubble = 1'b1;
                    end else if (load_use) begin
                        PCWrite     = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        state_d = RUN;
                    end else if (tcnt_q == TLAST) begin
                        // Abort: let stages advance, kill the access.
                        err_d        = 1'b1;
                        MEMWB_Bubble = 1'b1;
                        EXMEM_Bubble = 1'b1;
                        state_d      = RUN;
                    end else begin
                        PCWrite      = 1'b0;
                        IFID_Write   = 1'b0;
                        IDEX_Write   = 1'b0;
                        EXMEM_Write  = 1'b0;
                        MEMWB_Bubble = 1'b1;
                        tcnt_d       = tcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
            tcnt_q  <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    // PCSrc is only ever raised by a taken-branch flush outside reset.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!Reset && !PCWrite && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (!Reset && PCSrc && (flush_q != '1)) begin
            flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed literal checks plus
// randomized stimulus compared each cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 4;
    localparam longint MAXC = 64'hFFFF_FFFF;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [4:0]  IFID_rs = '0, IFID_rt = '0, IDEX_rt = '0;
    logic        IFID_uses_rt = 0, IDEX_MemRead = 0;
    logic        EXMEM_MemRead = 0, EXMEM_MemWrite = 0;
    logic        EXMEM_Branch = 0, EXMEM_Zero = 0, mem_ack = 0;
    logic        PCWrite, PCSrc, IFID_Write, IFID_Flush;
    logic        IDEX_Write, IDEX_Bubble, EXMEM_Write, EXMEM_Bubble;
    logic        MEMWB_Bubble, mem_req, mem_err;
    logic [31:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_uses_rt(IFID_uses_rt),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
        .EXMEM_Branch(EXMEM_Branch), .EXMEM_Zero(EXMEM_Zero),
        .mem_ack(mem_ack),
        .PCWrite(PCWrite), .PCSrc(PCSrc),
        .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble),
        .EXMEM_Write(EXMEM_Write), .EXMEM_Bubble(EXMEM_Bubble),
        .MEMWB_Bubble(MEMWB_Bubble), .mem_req(mem_req), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: is a memory access outstanding, how many wait cycles so far,
    // sticky error, and event tallies.
    bit     m_wait = 0;
    int     m_waited = 0;
    bit     m_err = 0;
    longint m_stall = 0, m_flush = 0;

    function automatic bit hazard();
        return IDEX_MemRead && IDEX_rt != 0 &&
               (IDEX_rt == IFID_rs || (IFID_uses_rt && IDEX_rt == IFID_rt));
    endfunction

    // Expected output vector order:
    // PCWrite PCSrc IFW IFF IDW IDB EXW EXB WBB req
    always @(negedge Clk) begin
        if (chk_en) begin
            logic [9:0] e;
            logic [9:0] a;
            bit frz, adv_abort, flush_ev;
            bit n_wait, n_err;
            int n_waited;
            longint es, ef;
            #2;
            e = 10'b1_0_1_0_1_0_1_0_0_0;
            frz = 0; adv_abort = 0; flush_ev = 0;
            n_wait = m_wait; n_waited = m_waited; n_err = m_err;
            if (Reset) begin
                e = 10'b0_0_0_1_0_1_0_1_1_0;
                n_wait = 0; n_waited = 0; n_err = 0;
            end else if (m_wait) begin
                e[0] = 1;
                if (mem_ack) n_wait = 0;
                else if (m_waited == TO - 1) begin
                    adv_abort = 1; n_err = 1; n_wait = 0;
                end else begin
                    frz = 1; n_waited = m_waited + 1;
                end
            end else begin
                e[0] = EXMEM_MemRead | EXMEM_MemWrite;
                if (e[0] && !mem_ack) begin
                    frz = 1; n_wait = 1; n_waited = 0;
                end else if (EXMEM_Branch && EXMEM_Zero) begin
                    flush_ev = 1;
                    e[8] = 1; e[6] = 1; e[4] = 1; e[2] = 1;
                end else if (hazard()) begin
                    e[9] = 0; e[7] = 0; e[4] = 1;
                end
            end
            if (frz) begin
                e[9] = 0; e[7] = 0; e[5] = 0; e[3] = 0; e[1] = 1;
            end
            if (adv_abort) begin
                e[1] = 1; e[2] = 1;
            end
            a = {PCWrite, PCSrc, IFID_Write, IFID_Flush, IDEX_Write,
                 IDEX_Bubble, EXMEM_Write, EXMEM_Bubble, MEMWB_Bubble,
                 mem_req};
`ifdef PIPE_HAZARD_STATS_EN
            es = m_stall; ef = m_flush;
`else
            es = 0; ef = 0;
`endif
            chk("ctrl_vec", 64'(a), 64'(e));
            chk("mem_err", 64'(mem_err), 64'(m_err));
            chk("stall_cnt", 64'(stall_cnt), es);
            chk("flush_cnt", 64'(flush_cnt), ef);
            if (Reset) begin
                m_stall = 0; m_flush = 0;
            end else begin
                if (!e[9] && m_stall < MAXC) m_stall++;
                if (flush_ev && m_flush < MAXC) m_flush++;
            end
            m_wait = n_wait; m_waited = n_waited; m_err = n_err;
        end
    end

    task automatic drv(input bit rst, input logic [4:0] rs, rt,
                       input bit urt, idrd, input logic [4:0] idrt,
                       input bit exrd, exwr, br, z, ack);
        @(negedge Clk);
        Reset = rst; IFID_rs = rs; IFID_rt = rt; IFID_uses_rt = urt;
        IDEX_MemRead = idrd; IDEX_rt = idrt;
        EXMEM_MemRead = exrd; EXMEM_MemWrite = exwr;
        EXMEM_Branch = br; EXMEM_Zero = z; mem_ack = ack;
        #3;
    endtask

    task automatic idle(input bit rst);
        drv(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic memop(input bit rd, wr, ack);
        drv(0, 0, 0, 0, 0, 0, rd, wr, 0, 0, ack);
    endtask

    initial begin
        chk_en = 1;
        idle(1);
        idle(1);
        chk("rst_pcw", 64'(PCWrite), 0);
        chk("rst_enables", 64'({IFID_Write, IDEX_Write, EXMEM_Write}), 0);
        chk("rst_bubbles", 64'({IFID_Flush, IDEX_Bubble, EXMEM_Bubble,
                                MEMWB_Bubble}), 64'hF);
        chk("rst_memreq_err", 64'({mem_req, mem_err}), 0);
        idle(0);
        chk("dflt_en", 64'({PCWrite, IFID_Write, IDEX_Write,
                             EXMEM_Write}), 64'hF);
        chk("dflt_bub", 64'({PCSrc, IFID_Flush, IDEX_Bubble,
                              EXMEM_Bubble, MEMWB_Bubble}), 0);
        drv(0, 8, 3, 0, 1, 8, 0, 0, 0, 0, 0);
        chk("lu_stall", 64'({PCWrite, IFID_Write, IDEX_Bubble,
                              IDEX_Write}), 64'b0011);
        drv(0, 8, 3, 0, 0, 8, 0, 0, 0, 0, 0);
        chk("lu_clear", 64'({PCWrite, IFID_Write, IDEX_Bubble}), 64'b110);
        drv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        chk("lu_r0", 64'({PCWrite, IDEX_Bubble}), 64'b10);
        drv(0, 8, 3, 0, 1, 8, 0, 0, 1, 1, 0);
        chk("br_over_lu", 64'({PCSrc, IFID_Flush, IDEX_Bubble,
                                EXMEM_Bubble, PCWrite}), 64'h1F);
        memop(1, 0, 0);
        chk("mr_c1", 64'({mem_req, PCWrite, MEMWB_Bubble}), 64'b101);
        memop(1, 0, 0);
        chk("mr_c2", 64'({mem_req, PCWrite, EXMEM_Write}), 64'b100);
        memop(1, 0, 1);
        chk("mr_ack", 64'({mem_req, PCWrite, MEMWB_Bubble}), 64'b110);
        memop(0, 0, 0);
        chk("mr_run", 64'({mem_req, PCWrite}), 64'b01);
        for (int i = 0; i < TO; i++) begin
            memop(0, 1, 0);
            chk("to_freeze", 64'({mem_req, PCWrite}), 64'b10);
        end
        memop(0, 1, 0);
        chk("to_abort", 64'({PCWrite, EXMEM_Bubble, MEMWB_Bubble,
                              mem_err}), 64'b1110);
        memop(0, 0, 0);
        chk("to_err", 64'({mem_err, mem_req}), 64'b10);
`ifdef PIPE_HAZARD_STATS_EN
        chk("stat_stall", 64'(stall_cnt), 7);
        chk("stat_flush", 64'(flush_cnt), 1);
`else
        chk("stat_stall", 64'(stall_cnt), 0);
        chk("stat_flush", 64'(flush_cnt), 0);
`endif
        memop(1, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        chk("rst_mid_req", 64'(mem_req), 0);
        memop(0, 0, 0);
        chk("rst_mid_run", 64'({mem_req, PCWrite, mem_err}), 64'b010);
        for (int i = 0; i < 3000; i++) begin
            drv(($urandom_range(99) < 2),
                5'($urandom_range(3)), 5'($urandom_range(3)),
                1'($urandom), ($urandom_range(99) < 40),
                5'($urandom_range(3)),
                ($urandom_range(99) < 20), ($urandom_range(99) < 15),
                ($urandom_range(99) < 25), 1'($urandom),
                ($urandom_range(99) < 30));
        end
        idle(0);
        @(negedge Clk);
        #4;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
